counter_ctrl: RTL and testbench

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_pkg.sv | 14 +
 rtl/toggle_bit.sv | 31 +++
 rtl/counter_ctrl.sv | 137 +++++++++++++
 tb/tb_counter_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and default parameters for the counter_ctrl block.
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned W_DEF        = 4;
    localparam int unsigned PRESCALE_DEF = 4;

endpackage

// File: rtl/toggle_bit.sv
// One count bit: toggle flop with synchronous clear and load (clear > load > toggle).
module toggle_bit (
    input  logic clk,
    input  logic clr_i,
    input  logic ld_i,
    input  logic ld_val_i,
    input  logic tgl_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = 1'b0;
        end else if (ld_i) begin
            q_d = ld_val_i;
        end else if (tgl_i) begin
            q_d = ~q_q;
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/counter_ctrl.sv
// Start/stop/pause counter with terminal-count detection, auto-reload and a one-cycle done pulse.
// Optional tick prescaler compiled in with COUNTER_CTRL_PRESCALE_EN; all outputs are registered.
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int unsigned W        = W_DEF,
    parameter int unsigned PRESCALE = PRESCALE_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] term_val,
    input  logic         auto_reload,
    output logic [W-1:0] count,
    output logic         busy,
    output logic         done
);

    state_t state_q, state_d;
    logic   done_q, done_d;
    logic   cnt_clr, cnt_ld, cnt_inc;
    logic   ps_zero, ps_inc;
    logic   tick;
    logic   term_hit;

    assign term_hit = (count == term_val);

    // Inputs are decoded strictly in priority order; an input masked by a
    // higher-priority one has no effect, even when that one is itself a no-op.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_ld  = 1'b0;
        cnt_inc = 1'b0;
        ps_zero = 1'b0;
        ps_inc  = 1'b0;
        if (reset || clear) begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
            ps_zero = 1'b1;
        end else if (stop) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSE;
            end
        end else if (start && (state_q != ST_RUN)) begin
            state_d = ST_RUN;
            cnt_clr = (state_q == ST_DONE);
            ps_zero = (state_q != ST_PAUSE);
        end else if (load && ((state_q == ST_IDLE) || (state_q == ST_PAUSE))) begin
            cnt_ld = 1'b1;
        end else if (state_q == ST_RUN) begin
            ps_inc = 1'b1;
            if (tick) begin
                if (term_hit) begin
                    done_d = 1'b1;
                    if (auto_reload) begin
                        cnt_clr = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

`ifdef COUNTER_CTRL_PRESCALE_EN
    localparam int unsigned    PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] ps_q, ps_d;

    assign tick = (ps_q == PS_LAST);

    always_comb begin
        ps_d = ps_q;
        if (ps_zero) begin
            ps_d = '0;
        end else if (ps_inc) begin
            ps_d = tick ? '0 : ps_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end
`else
    logic unused_ps;

    assign tick      = 1'b1;
    assign unused_ps = ^{ps_zero, ps_inc, PRESCALE[0]};
`endif

    // Ripple-carry toggle enables: bit i flips when incrementing and all lower bits are one.
    logic [W-1:0] tgl;

    for (genvar i = 0; i < W; i++) begin : g_bit
        if (i == 0) begin : g_lsb
            assign tgl[i] = cnt_inc;
        end else begin : g_upper
            assign tgl[i] = cnt_inc & (&count[i-1:0]);
        end

        toggle_bit u_bit (
            .clk      (clk),
            .clr_i    (cnt_clr),
            .ld_i     (cnt_ld),
            .ld_val_i (load_val[i]),
            .tgl_i    (tgl[i]),
            .q_o      (count[i])
        );
    end

    assign busy = (state_q == ST_RUN);
    assign done = done_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: directed vector table, corner sequences, random vs. reference model.
module tb_counter_ctrl;

    localparam int W        = 4;
    localparam int PRESCALE = 4;
`ifdef COUNTER_CTRL_PRESCALE_EN
    localparam int PS_PERIOD = PRESCALE;
`else
    localparam int PS_PERIOD = 1;
`endif

    logic         clk = 1'b0;
    logic         reset, start, stop, clear, load, auto_reload;
    logic [W-1:0] load_val, term_val, count;
    logic         busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    counter_ctrl #(.W(W), .PRESCALE(PRESCALE)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .load        (load),
        .load_val    (load_val),
        .term_val    (term_val),
        .auto_reload (auto_reload),
        .count       (count),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        logic rst, st, sp, cl, ld;
        int   lv, tv;
        logic ar;
        int   ec;
        logic eb, ed;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic st, input logic sp, input logic cl,
                                input logic ld, input int lv, input int tv, input logic ar,
                                input int ec, input logic eb, input logic ed);
        vec_t v;
        v.rst = rst; v.st = st; v.sp = sp; v.cl = cl; v.ld = ld;
        v.lv = lv; v.tv = tv; v.ar = ar; v.ec = ec; v.eb = eb; v.ed = ed;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic st, input logic sp, input logic cl,
                         input logic ld, input int lv, input int tv, input logic ar);
        reset = rst; start = st; stop = sp; clear = cl; load = ld;
        load_val = W'(lv); term_val = W'(tv); auto_reload = ar;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: mode 0=idle 1=counting 2=paused 3=finished.
    int m_mode, m_count, m_ps;
    bit m_done;

    task automatic model_step(input logic rst, input logic st, input logic sp, input logic cl,
                              input logic ld, input int lv, input int tv, input logic ar);
        m_done = 0;
        if (rst || cl) begin
            m_mode = 0; m_count = 0; m_ps = 0;
        end else if (sp) begin
            if (m_mode == 1) m_mode = 2;
        end else if (st && m_mode != 1) begin
            if (m_mode != 2) m_ps = 0;
            if (m_mode == 3) m_count = 0;
            m_mode = 1;
        end else if (ld && (m_mode == 0 || m_mode == 2)) begin
            m_count = lv;
        end else if (m_mode == 1) begin
            bit hit = (m_ps == PS_PERIOD - 1);
            m_ps = (m_ps + 1) % PS_PERIOD;
            if (hit) begin
                if (m_count == tv) begin
                    m_done = 1;
                    if (ar) m_count = 0;
                    else    m_mode  = 3;
                end else begin
                    m_count = (m_count + 1) % (1 << W);
                end
            end
        end
    endtask

    initial begin
        vec_t tbl[$];
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        step();

`ifndef COUNTER_CTRL_PRESCALE_EN
        // Directed table: run to terminal, load/wrap, stop/resume, clear, reset at terminal.
        tbl.push_back(mk(1,0,0,0,0, 0,5,0, 0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 0,5,0, 0,1,0));
        for (int c = 1; c <= 5; c++) tbl.push_back(mk(0,0,0,0,0, 0,5,0, c,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,5,0, 5,0,1));
        tbl.push_back(mk(0,0,0,0,0, 0,5,0, 5,0,0));
        tbl.push_back(mk(0,0,0,0,1, 9,5,0, 5,0,0));
        tbl.push_back(mk(0,1,0,0,0, 0,5,0, 0,1,0));
        tbl.push_back(mk(0,0,0,1,0, 0,5,0, 0,0,0));
        tbl.push_back(mk(0,0,0,0,1, 14,1,0, 14,0,0));
        tbl.push_back(mk(0,1,0,0,0, 0,1,0, 14,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,1,0, 15,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,1,0, 0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,1,0, 1,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,1,0, 1,0,1));
        tbl.push_back(mk(0,1,1,0,0, 0,1,0, 1,0,0));
        tbl.push_back(mk(0,1,0,0,0, 0,3,1, 0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,3,1, 1,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,3,1, 2,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,3,1, 3,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,3,1, 0,1,1));
        tbl.push_back(mk(0,0,0,0,1, 7,3,1, 1,1,0));
        tbl.push_back(mk(0,0,1,0,0, 0,3,1, 1,0,0));
        tbl.push_back(mk(0,0,0,0,1, 9,3,1, 9,0,0));
        tbl.push_back(mk(0,1,0,0,0, 0,3,1, 9,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,3,1, 10,1,0));
        tbl.push_back(mk(0,1,0,1,0, 0,3,1, 0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 0,0,0, 0,1,0));
        tbl.push_back(mk(1,0,0,0,0, 0,0,0, 0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 0,0,0, 0,1,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,1));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].st, tbl[i].sp, tbl[i].cl, tbl[i].ld,
                  tbl[i].lv, tbl[i].tv, tbl[i].ar);
            step();
            chk($sformatf("vec%0d count", i), int'(count), tbl[i].ec);
            chk($sformatf("vec%0d busy", i), int'(busy), int'(tbl[i].eb));
            chk($sformatf("vec%0d done", i), int'(done), int'(tbl[i].ed));
        end

        // Auto-reload: term 3 for 12 cycles, done every 4th, busy never drops.
        drive(1, 0, 0, 0, 0, 0, 3, 1); step();
        drive(0, 1, 0, 0, 0, 0, 3, 1); step();
        drive(0, 0, 0, 0, 0, 0, 3, 1);
        for (int j = 1; j <= 12; j++) begin
            step();
            chk($sformatf("reload count j%0d", j), int'(count), j % 4);
            chk($sformatf("reload done j%0d", j), int'(done), int'(j % 4 == 0));
            chk($sformatf("reload busy j%0d", j), int'(busy), 1);
        end

        // Pause at 3 for five cycles, then resume at 4; clear beats start.
        drive(1, 0, 0, 0, 0, 0, 15, 0); step();
        drive(0, 1, 0, 0, 0, 0, 15, 0); step();
        drive(0, 0, 0, 0, 0, 0, 15, 0); step(); step(); step();
        chk("pause pre count", int'(count), 3);
        drive(0, 0, 1, 0, 0, 0, 15, 0); step();
        drive(0, 0, 0, 0, 0, 0, 15, 0);
        for (int j = 0; j < 5; j++) begin
            step();
            chk($sformatf("pause hold count j%0d", j), int'(count), 3);
            chk($sformatf("pause hold busy j%0d", j), int'(busy), 0);
        end
        drive(0, 1, 0, 0, 0, 0, 15, 0); step();
        chk("resume count", int'(count), 3);
        chk("resume busy", int'(busy), 1);
        drive(0, 0, 0, 0, 0, 0, 15, 0); step();
        chk("resume next count", int'(count), 4);
        drive(0, 1, 0, 1, 0, 0, 15, 0); step();
        chk("clear+start count", int'(count), 0);
        chk("clear+start busy", int'(busy), 0);
`else
        // Prescaled: term 2, count advances every 4 cycles, done after 12th counting cycle.
        drive(1, 0, 0, 0, 0, 0, 2, 0); step();
        drive(0, 1, 0, 0, 0, 0, 2, 0); step();
        chk("ps start count", int'(count), 0);
        chk("ps start busy", int'(busy), 1);
        drive(0, 0, 0, 0, 0, 0, 2, 0);
        for (int j = 1; j <= 12; j++) begin
            step();
            chk($sformatf("ps count j%0d", j), int'(count), (j == 12) ? 2 : j / 4);
            chk($sformatf("ps busy j%0d", j), int'(busy), int'(j < 12));
            chk($sformatf("ps done j%0d", j), int'(done), int'(j == 12));
        end
`endif

        // Random stimulus checked cycle-by-cycle against the reference model.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        for (int n = 0; n < 3000; n++) begin
            logic r_rst, r_st, r_sp, r_cl, r_ld, r_ar;
            int   r_lv, r_tv;
            r_rst = ($urandom_range(63) == 0);
            r_cl  = ($urandom_range(31) == 0);
            r_sp  = ($urandom_range(9) == 0);
            r_st  = ($urandom_range(3) == 0);
            r_ld  = ($urandom_range(7) == 0);
            r_ar  = ($urandom_range(1) == 0);
            r_lv  = int'($urandom_range((1 << W) - 1));
            r_tv  = ($urandom_range(1) == 0) ? int'($urandom_range(3)) : int'($urandom_range((1 << W) - 1));
            drive(r_rst, r_st, r_sp, r_cl, r_ld, r_lv, r_tv, r_ar);
            model_step(r_rst, r_st, r_sp, r_cl, r_ld, r_lv, r_tv, r_ar);
            step();
            chk($sformatf("rand%0d count", n), int'(count), m_count);
            chk($sformatf("rand%0d busy", n), int'(busy), int'(m_mode == 1));
            chk($sformatf("rand%0d done", n), int'(done), int'(m_done));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
